sigmoid_pipe: RTL and testbench

Pipelined, parametrised piecewise-linear sigmoid activation unit for the neuron datapath. It accepts one signed fixed-point sample per cycle over a valid/ready handshake and returns the activation three cycles later. It uses the four-segment PLAN approximation with shift-and-add only, and exploits symmetry for negative inputs. It replaces the single-slope, purely combinational activation with a wider-range, higher-accuracy, backpressure-aware stage that sits between the MAC accumulator and the layer output buffer.

---
 rtl/sigmoid_pipe.sv | 112 +++++++++++
 tb/tb_sigmoid_pipe.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_pipe.sv
// sigmoid_pipe: three-stage PLAN piecewise-linear sigmoid with valid/ready flow control.
// Define SIGMOID_TANH_EN to add the per-sample in_tanh select (tanh(x) = 2*sigmoid(2x) - 1).
module sigmoid_pipe #(
  parameter int INT_W  = 6,
  parameter int FRAC_W = 10,
  parameter int DATA_W = INT_W + FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
`ifdef SIGMOID_TANH_EN
  input  logic              in_tanh,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_y,
  output logic              out_sat
);
  localparam logic [DATA_W-1:0] MAXP  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MINN  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] ONE   = DATA_W'(1 << FRAC_W);
  localparam logic [DATA_W-1:0] FIVE  = DATA_W'(5 << FRAC_W);
  localparam logic [DATA_W-1:0] T2375 = DATA_W'(19 << (FRAC_W-3));
  localparam logic [DATA_W-1:0] OFF2  = DATA_W'(27 << (FRAC_W-5));
  localparam logic [DATA_W-1:0] OFF1  = DATA_W'(5 << (FRAC_W-3));
  localparam logic [DATA_W-1:0] OFF0  = DATA_W'(1 << (FRAC_W-1));

  logic              v1_q, neg1_q, v2_q, neg2_q, sat2_q, v3_q, sat3_q;
  logic [DATA_W-1:0] a1_q, s2_q, y3_q;
  logic [1:0]        seg1_q;
  logic              ld1, ld2, ld3;
  logic [DATA_W-1:0] xs_d, a_d, s_d, sig_d, y_d;
  logic [1:0]        seg_d;
`ifdef SIGMOID_TANH_EN
  logic              mode1_q, mode2_q;
  logic [DATA_W-1:0] x2_d;
`endif

  always_comb begin
    ld3 = !v3_q || out_ready;
    ld2 = !v2_q || ld3;
    ld1 = !v1_q || ld2;
    in_ready = ld1;
`ifdef SIGMOID_TANH_EN
    x2_d = (in_x[DATA_W-1] ^ in_x[DATA_W-2]) ? (in_x[DATA_W-1] ? MINN : MAXP) : {in_x[DATA_W-2:0], 1'b0};
    xs_d = in_tanh ? x2_d : in_x;
`else
    xs_d = in_x;
`endif
    a_d = (xs_d == MINN) ? MAXP : xs_d[DATA_W-1] ? -xs_d : xs_d;
    seg_d = (a_d >= FIVE) ? 2'd3 : (a_d >= T2375) ? 2'd2 : (a_d >= ONE) ? 2'd1 : 2'd0;
    s_d = (seg1_q == 2'd3) ? ONE :
          (seg1_q == 2'd2) ? (a1_q >> 5) + OFF2 :
          (seg1_q == 2'd1) ? (a1_q >> 3) + OFF1 : (a1_q >> 2) + OFF0;
    sig_d = neg2_q ? ONE - s2_q : s2_q;
`ifdef SIGMOID_TANH_EN
    y_d = mode2_q ? {sig_d[DATA_W-2:0], 1'b0} - ONE : sig_d;
`else
    y_d = sig_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      a1_q   <= '0;
      neg1_q <= 1'b0;
      seg1_q <= 2'd0;
      v2_q   <= 1'b0;
      s2_q   <= '0;
      neg2_q <= 1'b0;
      sat2_q <= 1'b0;
      v3_q   <= 1'b0;
      y3_q   <= '0;
      sat3_q <= 1'b0;
`ifdef SIGMOID_TANH_EN
      mode1_q <= 1'b0;
      mode2_q <= 1'b0;
`endif
    end else begin
      if (ld1) v1_q <= in_valid;
      if (ld1 && in_valid) begin
        a1_q   <= a_d;
        neg1_q <= xs_d[DATA_W-1];
        seg1_q <= seg_d;
`ifdef SIGMOID_TANH_EN
        mode1_q <= in_tanh;
`endif
      end
      if (ld2) v2_q <= v1_q;
      if (ld2 && v1_q) begin
        s2_q   <= s_d;
        neg2_q <= neg1_q;
        sat2_q <= &seg1_q;
`ifdef SIGMOID_TANH_EN
        mode2_q <= mode1_q;
`endif
      end
      if (ld3) v3_q <= v2_q;
      if (ld3 && v2_q) begin
        y3_q   <= y_d;
        sat3_q <= sat2_q;
      end
    end
  end

  assign out_valid = v3_q;
  assign out_y     = y3_q;
  assign out_sat   = sat3_q;
endmodule

// File: tb/tb_sigmoid_pipe.sv
// tb_sigmoid_pipe: directed and random checks of sigmoid_pipe against an arithmetic reference model.
module tb_sigmoid_pipe;
  logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, tanh_v = 0;
  logic        in_ready, out_valid, out_sat;
  logic [15:0] in_x = 0, out_y;
  int          checks = 0, errors = 0;
  int          q_y[$];
  bit          q_s[$];
  bit          prev_stall = 0;
  logic [15:0] prev_y = 0;

  sigmoid_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
`ifdef SIGMOID_TANH_EN
    .in_tanh(tanh_v),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_sat(out_sat));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: 1.0 = 1024, breakpoints 1.0, 2.375, 5.0 on |x|.
  function automatic void model(input int x, input bit t, output int y, output bit sat);
    int xv, a, s;
    xv = x;
    if (t) xv = (2 * x > 32767) ? 32767 : (2 * x < -32768) ? -32768 : 2 * x;
    a = (xv < 0) ? -xv : xv;
    if (a > 32767) a = 32767;
    sat = a >= 5120;
    s = sat ? 1024 : (a >= 2432) ? a / 32 + 864 : (a >= 1024) ? a / 8 + 640 : a / 4 + 512;
    y = (xv < 0) ? 1024 - s : s;
    if (t) y = 2 * y - 1024;
  endfunction

  function automatic logic [15:0] rnd_x();
    return ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 12000) - 6000);
  endfunction

  always @(negedge clk) begin
    int ey;
    bit es;
    if (!rst_n) begin
      q_y.delete();
      q_s.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_hold", int'(out_y), int'(prev_y));
      end
      if (out_valid && out_ready) begin
        if (q_y.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          ey = q_y.pop_front();
          es = q_s.pop_front();
          chk("stream_y", int'($signed(out_y)), ey);
          chk("stream_sat", int'(out_sat), int'(es));
        end
      end
      if (in_valid && in_ready) begin
        model(int'($signed(in_x)), tanh_v, ey, es);
        q_y.push_back(ey);
        q_s.push_back(es);
      end
      prev_stall = out_valid && !out_ready;
      prev_y = out_y;
    end
  end

  task automatic send_one(input string tag, input int x, input bit t, input int ey, input bit es);
    int lat;
    @(posedge clk); #1;
    in_valid = 1; in_x = 16'(x); tanh_v = t;
    chk({tag, "_ready"}, int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 0; tanh_v = 0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_y"}, int'($signed(out_y)), ey);
    chk({tag, "_sat"}, int'(out_sat), int'(es));
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 0; out_ready = 1;
    while ((q_y.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", q_y.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int xs[6] = '{0, 512, -512, 1536, 3072, 6144};
    int ys[6] = '{512, 640, 384, 832, 960, 1024};
    int bx[6] = '{1024, 2431, 2432, 5119, 5120, -32768};
    int by[6] = '{768, 943, 940, 1023, 1024, 0};
    bit bs[6] = '{0, 0, 0, 0, 1, 1};
    int acc, sent, cyc, seen;
    bit f;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_y", int'(out_y), 0);
    chk("rst_sat", int'(out_sat), 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    chk("rst_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 6; i++) send_one($sformatf("single%0d", i), xs[i], 0, ys[i], i == 5);
    for (int i = 0; i < 6; i++) send_one($sformatf("bound%0d", i), bx[i], 0, by[i], bs[i]);

    in_valid = 1; in_x = rnd_x(); sent = 0; cyc = 0;
    while (sent < 20 && cyc < 500) begin
      out_ready = $urandom_range(0, 1) != 0;
      @(negedge clk); f = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (f) begin sent++; in_x = rnd_x(); end
    end
    chk("stream_sent", sent, 20);
    drain();

    out_ready = 0; in_valid = 1; in_x = rnd_x(); acc = 0;
    repeat (6) begin
      @(negedge clk); f = in_ready;
      @(posedge clk); #1;
      if (f) begin acc++; in_x = rnd_x(); end
    end
    chk("bp_accepted", acc, 3);
    chk("bp_in_ready", int'(in_ready), 0);
    out_ready = 1;
    repeat (6) begin
      @(negedge clk);
      chk("bp_thru_ready", int'(in_ready), 1);
      chk("bp_thru_valid", int'(out_valid), 1);
      @(posedge clk); #1;
      in_x = rnd_x();
    end
    drain();

    out_ready = 0; in_valid = 1; in_x = rnd_x(); acc = 0; cyc = 0;
    while (acc < 3 && cyc < 20) begin
      @(negedge clk); f = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (f) begin acc++; in_x = rnd_x(); end
    end
    in_valid = 0;
    chk("arst_pre_valid", int'(out_valid), 1);
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    chk("arst_valid_drop", int'(out_valid), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    out_ready = 1; seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("arst_no_stale", seen, 0);

`ifdef SIGMOID_TANH_EN
    send_one("tanh_512", 512, 1, 512, 0);
    send_one("sig_mid0", 1536, 0, 832, 0);
    send_one("tanh_m512", -512, 1, -512, 0);
    send_one("tanh_0", 0, 1, 0, 0);
    send_one("sig_mid1", -512, 0, 384, 0);
    send_one("tanh_max", 32767, 1, 1024, 1);
`endif
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
